// File: rtl/shift_fifo_pkg.sv
// Shared constants and types for the shift-register FIFO controller.
// Defaults match the 64x16 shift-register store.
package shift_fifo_pkg;
  localparam int BIT_WIDTH     = 16;
  localparam int NUM_WORDS     = 64;
  localparam int ADDR_WIDTH    = 6;
  localparam int AFULL_THRESH  = 56;
  localparam int AEMPTY_THRESH = 8;

  typedef logic [ADDR_WIDTH:0]  level_t;
  typedef logic [BIT_WIDTH-1:0] word_t;
endpackage

// File: rtl/shift_fifo_occ_cnt.sv
// Up/down occupancy counter with status flags derived from the count.
// Ports: clk, inc/dec/clr controls; level, full, empty, almost_full, almost_empty.
import shift_fifo_pkg::*;

module shift_fifo_occ_cnt #(
  parameter int NUM_WORDS     = shift_fifo_pkg::NUM_WORDS,
  parameter int ADDR_WIDTH    = shift_fifo_pkg::ADDR_WIDTH,
  parameter int AFULL_THRESH  = shift_fifo_pkg::AFULL_THRESH,
  parameter int AEMPTY_THRESH = shift_fifo_pkg::AEMPTY_THRESH
) (
  input  logic                clk,
  input  logic                inc,
  input  logic                dec,
  input  logic                clr,
  output logic [ADDR_WIDTH:0] level,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] C_FULL = LW'(NUM_WORDS);
  localparam logic [ADDR_WIDTH:0] C_AF   = LW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] C_AE   = LW'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] C_ONE  = LW'(1);

  logic [ADDR_WIDTH:0] r_level;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_level <= '0;
    end else if (inc && !dec) begin
      r_level <= r_level + C_ONE;
    end else if (dec && !inc) begin
      r_level <= r_level - C_ONE;
    end
  end

  assign level        = r_level;
  assign full         = (r_level == C_FULL);
  assign empty        = (r_level == '0);
  assign almost_full  = (r_level >= C_AF);
  assign almost_empty = (r_level <= C_AE);

endmodule

// File: rtl/shift_fifo_ctrl.sv
// FIFO controller over a shift-register store (newest word at index 0).
// Ports: fifo_clk/fifo_reset/flush, push and pop handshakes, status, store side.
import shift_fifo_pkg::*;

module shift_fifo_ctrl #(
  parameter int BIT_WIDTH     = shift_fifo_pkg::BIT_WIDTH,
  parameter int NUM_WORDS     = shift_fifo_pkg::NUM_WORDS,
  parameter int ADDR_WIDTH    = shift_fifo_pkg::ADDR_WIDTH,
  parameter int AFULL_THRESH  = shift_fifo_pkg::AFULL_THRESH,
  parameter int AEMPTY_THRESH = shift_fifo_pkg::AEMPTY_THRESH
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_reset,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [BIT_WIDTH-1:0]  push_data,
  output logic                  push_ready,
  input  logic                  pop_valid,
  output logic                  pop_ready,
  output logic                  pop_data_valid,
  output logic [BIT_WIDTH-1:0]  pop_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  sr_write_en,
  output logic [BIT_WIDTH-1:0]  sr_write_data,
  output logic [ADDR_WIDTH-1:0] sr_index,
  output logic                  sr_reset,
  input  logic [BIT_WIDTH-1:0]  sr_read_data
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] C_ONE = LW'(1);

  logic                w_clr;
  logic                w_push_fire;
  logic                w_pop_fire;
  logic [ADDR_WIDTH:0] w_idx;
  logic                r_pop_dv;

  // Reset/flush override both handshakes so neither is counted.
  assign w_clr       = fifo_reset | flush;
  assign push_ready  = ~full;
  assign pop_ready   = ~empty;
  assign w_push_fire = push_valid & push_ready & ~w_clr;
  assign w_pop_fire  = pop_valid & pop_ready & ~w_clr;

  shift_fifo_occ_cnt #(
    .NUM_WORDS    (NUM_WORDS),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .AFULL_THRESH (AFULL_THRESH),
    .AEMPTY_THRESH(AEMPTY_THRESH)
  ) u_occ (
    .clk         (fifo_clk),
    .inc         (w_push_fire),
    .dec         (w_pop_fire),
    .clr         (w_clr),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  // Oldest word sits at level-1; a push on the same edge shifts it
  // one place further, so the read index moves with it.
  always_comb begin
    w_idx = '0;
    if (w_pop_fire) begin
      w_idx = level + LW'(w_push_fire) - C_ONE;
    end else if (!empty) begin
      w_idx = level - C_ONE;
    end
  end

  assign sr_index      = w_idx[ADDR_WIDTH-1:0];
  assign sr_write_en   = w_push_fire;
  assign sr_write_data = push_data;
  assign sr_reset      = w_clr;

  always_ff @(posedge fifo_clk) begin
    if (w_clr) begin
      r_pop_dv <= 1'b0;
    end else begin
      r_pop_dv <= w_pop_fire;
    end
  end

  assign pop_data_valid = r_pop_dv;
  assign pop_data       = sr_read_data;

  a_level_max: assert property (@(posedge fifo_clk) disable iff (fifo_reset)
    level <= LW'(NUM_WORDS));
  a_no_push_full: assert property (@(posedge fifo_clk) disable iff (fifo_reset)
    !(w_push_fire && full));
  a_no_pop_empty: assert property (@(posedge fifo_clk) disable iff (fifo_reset)
    !(w_pop_fire && empty));
  a_pdv_src: assert property (@(posedge fifo_clk) disable iff (fifo_reset)
    pop_data_valid |-> $past(w_pop_fire));
  a_pd_known: assert property (@(posedge fifo_clk) disable iff (fifo_reset)
    pop_data_valid |-> !$isunknown(pop_data));

  c_full:  cover property (@(posedge fifo_clk) full);
  c_empty: cover property (@(posedge fifo_clk) empty);
  c_both:  cover property (@(posedge fifo_clk) w_push_fire && w_pop_fire);
  c_flush: cover property (@(posedge fifo_clk) flush && !empty);

endmodule

// File: tb/tb_shift_fifo_ctrl.sv
// Scoreboard bench for shift_fifo_ctrl with a behavioural 64x16 shift store.
// Stimulus queues expected pop words; a monitor checks them as they appear.
import shift_fifo_pkg::*;

module tb_shift_fifo_ctrl;

  logic        clk = 1'b0;
  logic        fifo_reset;
  logic        flush;
  logic        push_valid;
  word_t       push_data;
  logic        push_ready;
  logic        pop_valid;
  logic        pop_ready;
  logic        pop_data_valid;
  word_t       pop_data;
  level_t      level;
  logic        full, empty, almost_full, almost_empty;
  logic        sr_write_en;
  word_t       sr_write_data;
  logic [5:0]  sr_index;
  logic        sr_reset;
  word_t       sr_read_data;

  int total = 0;
  int bad   = 0;

  word_t exp_q[$];
  word_t mdl_q[$];
  int    m_level = 0;

  word_t mem [64];
  word_t nm  [64];

  always #5 clk = ~clk;

  shift_fifo_ctrl dut (
    .fifo_clk      (clk),
    .fifo_reset    (fifo_reset),
    .flush         (flush),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .pop_data_valid(pop_data_valid),
    .pop_data      (pop_data),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .sr_write_en   (sr_write_en),
    .sr_write_data (sr_write_data),
    .sr_index      (sr_index),
    .sr_reset      (sr_reset),
    .sr_read_data  (sr_read_data)
  );

  // Store: shift on write, registered read of the post-shift contents.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    sr_read_data = '0;
  end

  always @(posedge clk) begin
    nm = mem;
    if (sr_write_en) begin
      for (int i = 63; i > 0; i--) nm[i] = mem[i-1];
      nm[0] = sr_write_data;
    end
    mem <= nm;
    sr_read_data <= nm[sr_index];
  end

  task automatic chk(input string nm_s, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm_s, act, expv, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (pop_data_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_data: got unexpected %h want none at %0t",
                 pop_data, $time);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (pop_data !== e) begin
          bad++;
          $display("FAIL pop_data: got %h want %h at %0t", pop_data, e, $time);
        end
      end
    end
  end

  // One cycle: drive, check status at negedge, update model, advance.
  task automatic step(input logic pv, input word_t pd,
                      input logic qv, input logic fl);
    logic pf, qf;
    int   idx;
    push_valid = pv;
    push_data  = pd;
    pop_valid  = qv;
    flush      = fl;
    @(negedge clk);
    chk("level", 32'(level), 32'(m_level));
    chk("push_ready", 32'(push_ready), 32'(m_level < 64));
    chk("pop_ready", 32'(pop_ready), 32'(m_level != 0));
    chk("full", 32'(full), 32'(m_level == 64));
    chk("empty", 32'(empty), 32'(m_level == 0));
    chk("almost_full", 32'(almost_full), 32'(m_level >= 56));
    chk("almost_empty", 32'(almost_empty), 32'(m_level <= 8));
    chk("sr_reset", 32'(sr_reset), 32'(fl));
    pf = pv && (m_level < 64) && !fl;
    qf = qv && (m_level != 0) && !fl;
    chk("sr_write_en", 32'(sr_write_en), 32'(pf));
    if (qf) begin
      idx = m_level - 1 + int'(pf);
      chk("sr_index", 32'(sr_index), 32'(idx));
    end
    if (fl) begin
      m_level = 0;
      mdl_q.delete();
    end else begin
      if (qf) exp_q.push_back(mdl_q.pop_front());
      if (pf) mdl_q.push_back(pd);
      m_level = m_level + int'(pf) - int'(qf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input word_t base);
    for (int i = 0; i < n; i++) step(1'b1, base + word_t'(i), 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    fifo_reset = 1'b1;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_valid  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pdv", 32'(pop_data_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_pop_ready", 32'(pop_ready), 32'd0);
    chk("rst_sr_reset", 32'(sr_reset), 32'd1);
    @(posedge clk);
    #1;
    fifo_reset = 1'b0;

    // Three words in, three out.
    step(1'b1, 16'hA001, 1'b0, 1'b0);
    step(1'b1, 16'hA002, 1'b0, 1'b0);
    step(1'b1, 16'hA003, 1'b0, 1'b0);
    pop_n(3);
    idle(2);

    // Fill to 64, refused 65th, drain.
    push_n(64, 16'h0000);
    step(1'b1, 16'h0040, 1'b0, 1'b0);
    pop_n(64);
    idle(2);

    // Level 10, then simultaneous push/pop at steady level.
    push_n(10, 16'h0100);
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'h0200 + word_t'(i), 1'b1, 1'b0);
    pop_n(10);
    idle(2);

    // Empty: push and pop together -> only push accepted.
    step(1'b1, 16'h5555, 1'b1, 1'b0);
    pop_n(1);
    idle(2);

    // Almost-full / almost-empty thresholds.
    push_n(57, 16'h0300);
    pop_n(49);
    idle(1);

    // Grow to 20, pop, then flush while the popped word returns.
    push_n(12, 16'h0400);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(2);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    pop_n(1);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
